// File: rtl/crc32_fcs_tx.sv
`default_nettype none
// ============================================================================
// Module   : crc32_fcs_tx
// Brief    : Transmit FCS controller; pads short frames, appends CRC-32 FCS,
//            then holds off input for the inter-frame gap.
// Revision : 1.0  initial release
// ============================================================================
module crc32_fcs_tx #(
    parameter int MIN_LEN = 60,
    parameter int PAD_EN  = 1,
    parameter int IFG     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_dat,
    input  logic       in_val,
    input  logic       in_last,
    output logic       in_rdy,
    output logic [7:0] out_dat,
    output logic       out_val,
    output logic       out_last,
    input  logic       out_rdy,
    output logic       busy
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_data  = 3'd1;
    localparam logic [2:0]  c_st_pad   = 3'd2;
    localparam logic [2:0]  c_st_fcs   = 3'd3;
    localparam logic [2:0]  c_st_gap   = 3'd4;

    localparam logic [31:0] c_crc_init = 32'hFFFF_FFFF;
    localparam logic [31:0] c_poly     = 32'hEDB8_8320;
    localparam logic [15:0] c_min_len  = 16'(MIN_LEN);
    localparam logic [15:0] c_gap_last = 16'(IFG - 1);
    localparam bit          c_pad_en   = (PAD_EN != 0);

    // Reflected CRC-32, one byte LSB-first; equivalent to the 256-entry table step.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] v;
        v = crc ^ {24'd0, dat};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ c_poly) : (v >> 1);
        end
        return v;
    endfunction

    logic [2:0]  r_state;
    logic [31:0] r_crc;
    logic [15:0] r_cnt;
    logic [2:0]  r_fcs_idx;
    logic [15:0] r_gap_cnt;
    logic [7:0]  r_out_dat;
    logic        r_out_val;
    logic        r_out_last;

    logic [2:0]  w_state_nxt;
    logic [31:0] w_crc_nxt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_fcs_idx_nxt;
    logic [15:0] w_gap_cnt_nxt;
    logic [7:0]  w_out_dat_nxt;
    logic        w_out_val_nxt;
    logic        w_out_last_nxt;

    logic        w_ld;
    logic        w_in_xfer;
    logic [31:0] w_crc_base;
    logic [15:0] w_cnt_base;
    logic [15:0] w_cnt_inc;
    logic [31:0] w_crc_in;
    logic [31:0] w_crc_pad;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    // Output register may take a new byte when empty or being drained this cycle.
    assign w_ld      = !r_out_val || out_rdy;
    assign in_rdy    = !rst && ((r_state == c_st_idle) || (r_state == c_st_data)) && w_ld;
    assign w_in_xfer = in_val && in_rdy;

    // A frame always starts from the init value, whatever the register holds.
    assign w_crc_base = (r_state == c_st_idle) ? c_crc_init : r_crc;
    assign w_cnt_base = (r_state == c_st_idle) ? 16'd0 : r_cnt;
    assign w_cnt_inc  = (w_cnt_base == 16'hFFFF) ? w_cnt_base : (w_cnt_base + 16'd1);
    assign w_crc_in   = f_crc_byte(w_crc_base, in_dat);
    assign w_crc_pad  = f_crc_byte(r_crc, 8'h00);
    assign w_fcs      = ~r_crc;

    always_comb begin
        w_fcs_byte = w_fcs[7:0];
        case (r_fcs_idx[1:0])
            2'd0:    w_fcs_byte = w_fcs[7:0];
            2'd1:    w_fcs_byte = w_fcs[15:8];
            2'd2:    w_fcs_byte = w_fcs[23:16];
            default: w_fcs_byte = w_fcs[31:24];
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_crc_nxt      = r_crc;
        w_cnt_nxt      = r_cnt;
        w_fcs_idx_nxt  = r_fcs_idx;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_out_dat_nxt  = r_out_dat;
        w_out_val_nxt  = r_out_val;
        w_out_last_nxt = r_out_last;

        if (w_ld) begin
            w_out_val_nxt  = 1'b0;
            w_out_last_nxt = 1'b0;
        end

        case (r_state)
            c_st_idle, c_st_data: begin
                if (w_in_xfer) begin
                    w_out_dat_nxt = in_dat;
                    w_out_val_nxt = 1'b1;
                    w_crc_nxt     = w_crc_in;
                    w_cnt_nxt     = w_cnt_inc;
                    w_state_nxt   = c_st_data;
                    if (in_last) begin
                        w_fcs_idx_nxt = 3'd0;
                        w_state_nxt   = (c_pad_en && (w_cnt_inc < c_min_len)) ? c_st_pad : c_st_fcs;
                    end
                end
            end

            c_st_pad: begin
                if (w_ld) begin
                    w_out_dat_nxt = 8'h00;
                    w_out_val_nxt = 1'b1;
                    w_crc_nxt     = w_crc_pad;
                    w_cnt_nxt     = w_cnt_inc;
                    if (w_cnt_inc >= c_min_len) begin
                        w_fcs_idx_nxt = 3'd0;
                        w_state_nxt   = c_st_fcs;
                    end
                end
            end

            c_st_fcs: begin
                if (r_fcs_idx != 3'd4) begin
                    if (w_ld) begin
                        w_out_dat_nxt  = w_fcs_byte;
                        w_out_val_nxt  = 1'b1;
                        w_out_last_nxt = (r_fcs_idx == 3'd3);
                        w_fcs_idx_nxt  = r_fcs_idx + 3'd1;
                    end
                end else if (out_rdy) begin
                    // Final FCS byte leaves this cycle; the gap count starts next cycle.
                    w_crc_nxt     = c_crc_init;
                    w_cnt_nxt     = 16'd0;
                    w_gap_cnt_nxt = 16'd0;
                    w_state_nxt   = (IFG == 0) ? c_st_idle : c_st_gap;
                end
            end

            c_st_gap: begin
                if (r_gap_cnt >= c_gap_last) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_crc      <= c_crc_init;
            r_cnt      <= 16'd0;
            r_fcs_idx  <= 3'd0;
            r_gap_cnt  <= 16'd0;
            r_out_dat  <= 8'h00;
            r_out_val  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_crc      <= w_crc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fcs_idx  <= w_fcs_idx_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_out_dat  <= w_out_dat_nxt;
            r_out_val  <= w_out_val_nxt;
            r_out_last <= w_out_last_nxt;
        end
    end

    assign out_dat  = r_out_dat;
    assign out_val  = r_out_val;
    assign out_last = r_out_last;
    assign busy     = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_crc32_fcs_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32_fcs_tx
// Brief    : Bench for crc32_fcs_tx with padding on (inst 0) and off (inst 1),
//            checked against a frame-level CRC/padding model.
// Revision : 1.0  initial release
// ============================================================================
module tb_crc32_fcs_tx;

    localparam int c_min_len = 60;
    localparam int c_ifg     = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_val;
    logic [1:0] in_last;
    logic [1:0] in_rdy;
    logic [1:0] out_val;
    logic [1:0] out_last;
    logic [1:0] out_rdy = 2'b11;
    logic [1:0] busy;
    logic [7:0] in_dat  [2];
    logic [7:0] out_dat [2];
    logic [1:0] bp = 2'b00;

    always #5 clk = ~clk;

    crc32_fcs_tx #(.MIN_LEN(c_min_len), .PAD_EN(1), .IFG(c_ifg)) u_dut_pad (
        .clk(clk), .rst(rst),
        .in_dat(in_dat[0]), .in_val(in_val[0]), .in_last(in_last[0]), .in_rdy(in_rdy[0]),
        .out_dat(out_dat[0]), .out_val(out_val[0]), .out_last(out_last[0]), .out_rdy(out_rdy[0]),
        .busy(busy[0])
    );

    crc32_fcs_tx #(.MIN_LEN(c_min_len), .PAD_EN(0), .IFG(c_ifg)) u_dut_nopad (
        .clk(clk), .rst(rst),
        .in_dat(in_dat[1]), .in_val(in_val[1]), .in_last(in_last[1]), .in_rdy(in_rdy[1]),
        .out_dat(out_dat[1]), .out_val(out_val[1]), .out_last(out_last[1]), .out_rdy(out_rdy[1]),
        .busy(busy[1])
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] crc_tab [256];
    logic [8:0]  exp0 [$];
    logic [8:0]  exp1 [$];
    logic [7:0]  cap0 [$];
    logic [7:0]  cap1 [$];
    logic [7:0]  pl   [$];

    logic [31:0] res        [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int          run        [2] = '{0, 0};
    int          last_run   [2] = '{0, 0};
    int          gap_cnt    [2] = '{0, 0};
    bit          gap_on     [2] = '{0, 0};
    bit          stall_prev [2] = '{0, 0};
    logic [7:0]  dat_prev   [2] = '{8'h00, 8'h00};

    logic [7:0] lit_np   [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                  8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    int         lit_len  [3]  = '{59, 60, 61};
    int         lit_pads [3]  = '{1, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = 32'(i);
            for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
            crc_tab[i] = v;
        end
    end

    // Frame model: payload, zero pad up to the minimum if enabled, then ~CRC LSB-first.
    task automatic model_frame(input int d, input logic [7:0] p [$], input bit pad_en);
        logic [7:0]  fr [$];
        logic [31:0] c;
        fr = p;
        if (pad_en) while (fr.size() < c_min_len) fr.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (fr[i]) c = crc_step(c, fr[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
        foreach (fr[i]) begin
            if (d == 0) exp0.push_back({(i == fr.size() - 1), fr[i]});
            else        exp1.push_back({(i == fr.size() - 1), fr[i]});
        end
    endtask

    task automatic drive_frame(input int d, input logic [7:0] p [$], input int stop_after);
        for (int i = 0; i < p.size(); i++) begin
            bit acc;
            int t;
            acc = 1'b0;
            t   = 0;
            in_val[d]  = 1'b1;
            in_dat[d]  = p[i];
            in_last[d] = (i == p.size() - 1);
            while (!acc && t < 2000) begin
                @(negedge clk);
                acc = in_rdy[d];
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                chk("accept_timeout", 32'(acc), 32'd1);
                break;
            end
            if (stop_after == i + 1) break;
        end
        in_val[d]  = 1'b0;
        in_last[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int t;
        t = 0;
        while (((d == 0) ? exp0.size() : exp1.size()) != 0 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", 32'((d == 0) ? exp0.size() : exp1.size()), 32'd0);
    endtask

    task automatic on_xfer(input int d);
        logic [8:0] a;
        logic [8:0] e;
        bit         have;
        a    = {out_last[d], out_dat[d]};
        have = (d == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out%0d: got %h, expected no byte", d, a);
        end else begin
            e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
            chk($sformatf("out_byte%0d", d), 32'(a), 32'(e));
        end
        if (d == 0) cap0.push_back(out_dat[d]);
        else        cap1.push_back(out_dat[d]);
        res[d] = crc_step(res[d], out_dat[d]);
        if (out_last[d]) begin
            chk($sformatf("residue%0d", d), res[d], 32'hDEBB_20E3);
            res[d]      = 32'hFFFF_FFFF;
            last_run[d] = run[d];
            gap_on[d]   = 1'b1;
            gap_cnt[d]  = 0;
        end
    endtask

    // Single compare process: byte stream, stall stability, inter-frame gap length.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && stall_prev[d]) begin
                chk($sformatf("stall_val%0d", d), 32'(out_val[d]), 32'd1);
                chk($sformatf("stall_dat%0d", d), 32'(out_dat[d]), 32'(dat_prev[d]));
            end
            if (gap_on[d]) begin
                if (rst) begin
                    gap_on[d] = 1'b0;
                end else if (in_rdy[d] || gap_cnt[d] > 1000) begin
                    chk($sformatf("ifg_len%0d", d), 32'(gap_cnt[d]), 32'(c_ifg));
                    gap_on[d] = 1'b0;
                end else begin
                    gap_cnt[d]++;
                end
            end
            run[d] = out_val[d] ? run[d] + 1 : 0;
            if (out_val[d] && out_rdy[d]) on_xfer(d);
            if (rst) res[d] = 32'hFFFF_FFFF;
            stall_prev[d] = out_val[d] && !out_rdy[d];
            dat_prev[d]   = out_dat[d];
        end
    end

    always begin
        @(posedge clk);
        #1;
        out_rdy[0] = bp[0] ? 1'($urandom_range(0, 1)) : 1'b1;
        out_rdy[1] = bp[1] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load_ascii_9();
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    endtask

    task automatic load_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [31:0] c;
        rst     = 1'b1;
        in_val  = 2'b00;
        in_last = 2'b00;
        in_dat  = '{8'h00, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_in_rdy%0d", d),   32'(in_rdy[d]),   32'd0);
            chk($sformatf("rst_out_val%0d", d),  32'(out_val[d]),  32'd0);
            chk($sformatf("rst_out_last%0d", d), 32'(out_last[d]), 32'd0);
            chk($sformatf("rst_out_dat%0d", d),  32'(out_dat[d]),  32'd0);
            chk($sformatf("rst_busy%0d", d),     32'(busy[d]),     32'd0);
        end
        rst = 1'b0;

        // Model pin: CRC-32 check value of "123456789".
        load_ascii_9();
        c = 32'hFFFF_FFFF;
        foreach (pl[i]) c = crc_step(c, pl[i]);
        chk("model_check_value", ~c, 32'hCBF4_3926);

        // No padding, straight-through stream.
        cap1.delete();
        model_frame(1, pl, 1'b0);
        drive_frame(1, pl, -1);
        wait_drain(1);
        chk("nopad_len", 32'(cap1.size()), 32'd13);
        for (int i = 0; i < 13 && i < cap1.size(); i++)
            chk($sformatf("nopad_lit%0d", i), 32'(cap1[i]), 32'(lit_np[i]));
        chk("nopad_run", 32'(last_run[1]), 32'd13);

        // Reset mid-frame after 5 of 20 bytes.
        repeat (20) @(posedge clk);
        #1;
        load_random(20);
        for (int i = 0; i < 5; i++) exp1.push_back({1'b0, pl[i]});
        drive_frame(1, pl, 5);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_rdy", 32'(in_rdy[1]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_out_val", 32'(out_val[1]), 32'd0);
        chk("rst_mid_busy", 32'(busy[1]), 32'd0);
        chk("rst_mid_pending", 32'(exp1.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        load_ascii_9();
        cap1.delete();
        model_frame(1, pl, 1'b0);
        drive_frame(1, pl, -1);
        wait_drain(1);
        for (int i = 0; i < 4 && cap1.size() == 13; i++)
            chk($sformatf("post_rst_fcs%0d", i), 32'(cap1[9 + i]), 32'(lit_np[9 + i]));
        chk("post_rst_len", 32'(cap1.size()), 32'd13);

        // Single-byte frame padded to the minimum.
        pl.delete();
        pl.push_back(8'hAA);
        cap0.delete();
        model_frame(0, pl, 1'b1);
        drive_frame(0, pl, -1);
        wait_drain(0);
        chk("pad_len", 32'(cap0.size()), 32'd64);
        if (cap0.size() != 0) chk("pad_first", 32'(cap0[0]), 32'h0000_00AA);

        // 100-byte frame with random backpressure, then the same frame unstalled.
        load_random(100);
        repeat (15) @(posedge clk);
        #1;
        bp[0] = 1'b1;
        cap0.delete();
        model_frame(0, pl, 1'b1);
        drive_frame(0, pl, -1);
        wait_drain(0);
        chk("bp_len", 32'(cap0.size()), 32'd104);
        bp[0] = 1'b0;
        cap0.delete();
        model_frame(0, pl, 1'b1);
        drive_frame(0, pl, -1);
        wait_drain(0);
        chk("nobp_len", 32'(cap0.size()), 32'd104);

        // Two frames offered back to back; gap length checked by the compare process.
        load_random(70);
        model_frame(0, pl, 1'b1);
        drive_frame(0, pl, -1);
        load_random(65);
        model_frame(0, pl, 1'b1);
        drive_frame(0, pl, -1);
        wait_drain(0);

        // Length boundary around the minimum.
        for (int k = 0; k < 3; k++) begin
            repeat (15) @(posedge clk);
            #1;
            load_random(lit_len[k]);
            cap0.delete();
            model_frame(0, pl, 1'b1);
            drive_frame(0, pl, -1);
            wait_drain(0);
            chk($sformatf("pad_count_len%0d", lit_len[k]),
                32'(cap0.size() - 4 - lit_len[k]), 32'(lit_pads[k]));
        end

        repeat (20) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc32_fcs_tx.md
# crc32_fcs_tx

Transmit-side frame check sequence controller. It accepts a byte stream framed by valid/ready/last, optionally pads short frames with zero bytes, and computes IEEE 802.3 CRC-32 over the frame. It appends the 4-byte FCS and then enforces an inter-frame gap before accepting the next frame. It sits between the MAC framer and the PHY byte interface and sequences the per-byte CRC update that the receive-side checker uses.

## Interface

- MIN_LEN, 60: minimum frame length in bytes before FCS; shorter frames are zero-padded when PAD_EN=1. Range 1..65535.
- PAD_EN, 1: 1 enables padding, 0 disables it.
- IFG, 12: idle cycles after the last FCS byte handshake. 0 is legal.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_dat  in  8  payload byte.
- in_val  in  1  in_dat valid.
- in_last  in  1  marks the final payload byte; qualified by in_val.
- in_rdy  out  1  block accepts the byte this cycle.
- out_dat  out  8  output byte.
- out_val  out  1  out_dat valid.
- out_last  out  1  marks the final FCS byte.
- out_rdy  in  1  downstream accepts the output byte.
- busy  out  1  high in every state except IDLE.

## Operation

- **Handshake rule:** an input transfer occurs when in_val & in_rdy. An output transfer occurs when out_val & out_rdy.
- **Output stage:** out_dat, out_val and out_last are registered. While out_val & !out_rdy they hold stable and no new byte is loaded.
- **Ready:** in_rdy = !rst & (state IDLE or DATA) & (!out_val | out_rdy).
- **CRC rules:**
  - Running register c resets to 0xFFFFFFFF at frame start.
  - Reflected polynomial 0xEDB88320, LSB-first, one byte per accepted or padded byte: c = table[(c ^ byte) & 0xFF] ^ (c >> 8).
  - FCS = ~c, emitted as bytes [7:0], [15:8], [23:16], [31:24].
- **Length counter:** 16 bits, counts payload and pad bytes, saturates at 0xFFFF.
- **States:**
  - IDLE: the first input transfer loads the output stage, sets count=1 and goes to DATA. If in_last is also set, it follows the DATA last-byte rule instead.
  - DATA: each transfer is forwarded and counted.
    - On a transfer with in_last: go to PAD if PAD_EN & count < MIN_LEN (count including this byte), else go to FCS.
  - PAD: emit 0x00 bytes, each folded into the CRC, until count == MIN_LEN, then go to FCS. in_rdy=0.
  - FCS: emit 4 bytes; out_last=1 only on the 4th. After the 4th is loaded and its output transfer completes, go to GAP, or to IDLE if IFG=0. in_rdy=0.
  - GAP: count IFG cycles with in_rdy=0, then go to IDLE.
- **Boundary conditions:**
  - A single-byte frame is legal.
  - Frames of length >= MIN_LEN get no padding.
  - MIN_LEN with PAD_EN=0 is ignored.
  - There are no empty frames; in_last is only meaningful with in_val.
- **Reset:** rst high at any time aborts the current frame without emitting an FCS.
  - Next cycle: state=IDLE, c=0xFFFFFFFF, count=0.
  - out_dat=0x00, out_val=0, out_last=0, busy=0, in_rdy=0 while rst=1.

## Timing

- **Latency:** a byte accepted on cycle N is on out_dat at N+1. Padding and FCS bytes follow back-to-back, one per output transfer, with no bubbles when out_rdy=1.
- **Throughput:** 1 byte/cycle with out_rdy held high. Frame overhead is max(0, MIN_LEN−len) pad bytes + 4 FCS bytes + IFG cycles.
- **Gap start:** the GAP count begins the cycle after the out_last transfer. The next frame's first byte is accepted no earlier than IFG+1 cycles after that transfer.
- **Backpressure:** out_rdy low stalls all states except GAP. The GAP count is independent of out_rdy.
- **Receive residue:** the CRC register (without final inversion) over payload + pad + FCS equals 0xDEBB20E3. The receive checker relies on this.

## Test plan

- **No padding:** PAD_EN=0, input ASCII "123456789" (0x31..0x39), out_rdy=1 → output 31..39 then 26 39 F4 CB; out_last only on CB; 13 consecutive out_val cycles.
- **Padding:** PAD_EN=1, MIN_LEN=60, single byte 0xAA with in_last → 0xAA, 59×0x00, 4 FCS bytes (64 total). The CRC residue over all 64 output bytes is 0xDEBB20E3.
- **Backpressure:** 100-byte random frame, out_rdy random 50% → output sequence identical to the out_rdy=1 run, and out_dat/out_val are stable during every stall.
- **Gap:** IFG=12, two back-to-back frames offered → in_rdy low for exactly 12 cycles after the first frame's out_last transfer, and the second frame's CRC starts from 0xFFFFFFFF.
- **Reset mid-operation:** assert rst for 1 cycle after 5 of 20 bytes → no FCS emitted; out_val=0 and busy=0 the next cycle. A following "123456789" frame yields FCS 26 39 F4 CB.
- **Length boundary:** frames of length MIN_LEN−1, MIN_LEN and MIN_LEN+1 → exactly 1, 0 and 0 pad bytes respectively.
